// File: rtl/atm_request_sequencer_if.sv
// Request/response port between the terminal front end and the ATM request sequencer.
// The front end is the master; the sequencer is the slave.
interface atm_request_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_acc;
    logic [15:0] req_pin;
    logic [2:0]  req_op;
    logic [31:0] req_amount;
    logic [15:0] req_new_pin;
    logic        req_lang;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_status;
    logic [31:0] rsp_balance;

    modport master (
        output req_valid, req_acc, req_pin, req_op, req_amount, req_new_pin, req_lang, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_balance
    );

    modport slave (
        input  req_valid, req_acc, req_pin, req_op, req_amount, req_new_pin, req_lang, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_balance
    );
endinterface

// File: rtl/atm_request_sequencer.sv
// Purpose: runs one customer transaction against the ATM core and returns one status response.
// Latency: response valid 5 cycles after accept on a compliant ATM; bad op answers the next cycle.
// Backpressure: req_ready only in idle; response held until rsp_ready. Watchdog: ATM_SEQ_TIMEOUT_EN.
module atm_request_sequencer #(
    parameter logic [2:0]  ST_WAITING = 3'd0,
    parameter logic [2:0]  ST_AUTH    = 3'd1,
    parameter logic [2:0]  ST_MENU    = 3'd2,
    parameter logic [3:0]  IDLE_ACC   = 4'hF
`ifdef ATM_SEQ_TIMEOUT_EN
   ,parameter logic [15:0] TIMEOUT    = 16'd64
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    atm_request_sequencer_if.slave      req_if,
    output logic [3:0]                  atm_acc_num,
    output logic [15:0]                 atm_pin,
    output logic [15:0]                 atm_new_pin,
    output logic [31:0]                 atm_amount,
    output logic                        atm_language,
    output logic [2:0]                  atm_operation,
    input  logic [2:0]                  atm_state,
    input  logic                        atm_success,
    input  logic [31:0]                 atm_balance
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_RESP} state_t;

    typedef struct packed {
        logic [3:0]  acc;
        logic [15:0] pin;
        logic [15:0] new_pin;
        logic [31:0] amount;
        logic        lang;
        logic [2:0]  op;
    } atm_drv_t;

    localparam atm_drv_t IDLE_DRV = atm_drv_t'({IDLE_ACC, 68'd0});

    localparam logic [2:0] RS_OK        = 3'd0;
    localparam logic [2:0] RS_DECLINED  = 3'd1;
    localparam logic [2:0] RS_AUTH_FAIL = 3'd2;
    localparam logic [2:0] RS_TIMEOUT   = 3'd3;
    localparam logic [2:0] RS_BAD_OP    = 3'd4;

    state_t      state;
    atm_drv_t    drv;
    atm_drv_t    req_drv;
    logic [2:0]  op_q;
    logic        saw_auth;
    logic        rsp_vld_q;
    logic [2:0]  rsp_status_q;
    logic [31:0] rsp_balance_q;
    logic        op_ok;
    logic        run_done;
    logic [2:0]  run_status;
    logic [31:0] run_balance;
    logic        wd_expired;

`ifdef ATM_SEQ_TIMEOUT_EN
    logic [15:0] wdog;
    assign wd_expired = (wdog == TIMEOUT - 16'd1);
`else
    assign wd_expired = 1'b0;
`endif

    assign req_drv = '{acc:     req_if.req_acc,
                       pin:     req_if.req_pin,
                       new_pin: req_if.req_new_pin,
                       amount:  req_if.req_amount,
                       lang:    req_if.req_lang,
                       op:      req_if.req_op};

    // Op codes sit directly above the MENU state code (ATM op-state codes equal op codes).
    assign op_ok = (req_if.req_op > ST_MENU) && (req_if.req_op < 3'd7);

    assign req_if.req_ready   = (state == S_IDLE);
    assign req_if.rsp_valid   = rsp_vld_q;
    assign req_if.rsp_status  = rsp_status_q;
    assign req_if.rsp_balance = rsp_balance_q;

    assign atm_acc_num   = drv.acc;
    assign atm_pin       = drv.pin;
    assign atm_new_pin   = drv.new_pin;
    assign atm_amount    = drv.amount;
    assign atm_language  = drv.lang;
    assign atm_operation = drv.op;

    // Completion conditions while the ATM is working, in priority order.
    always_comb begin
        run_done    = 1'b0;
        run_status  = RS_OK;
        run_balance = '0;
        if (atm_state == op_q) begin
            run_done    = 1'b1;
            run_status  = atm_success ? RS_OK : RS_DECLINED;
            run_balance = atm_balance;
        end else if (saw_auth && atm_state == ST_WAITING) begin
            run_done   = 1'b1;
            run_status = RS_AUTH_FAIL;
        end else if (wd_expired) begin
            run_done   = 1'b1;
            run_status = RS_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            drv           <= IDLE_DRV;
            op_q          <= '0;
            saw_auth      <= 1'b0;
            rsp_vld_q     <= 1'b0;
            rsp_status_q  <= RS_OK;
            rsp_balance_q <= '0;
`ifdef ATM_SEQ_TIMEOUT_EN
            wdog          <= '0;
`endif
        end else begin
`ifdef ATM_SEQ_TIMEOUT_EN
            if ((state == S_RUN || state == S_DRAIN) && wdog != 16'hFFFF)
                wdog <= wdog + 16'd1;
`endif
            case (state)
                S_IDLE: begin
                    if (req_if.req_valid) begin
                        op_q <= req_if.req_op;
                        if (!op_ok) begin
                            rsp_status_q  <= RS_BAD_OP;
                            rsp_balance_q <= '0;
                            rsp_vld_q     <= 1'b1;
                            state         <= S_RESP;
                        end else begin
                            drv      <= req_drv;
                            saw_auth <= 1'b0;
`ifdef ATM_SEQ_TIMEOUT_EN
                            wdog     <= '0;
`endif
                            state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (atm_state == ST_AUTH)
                        saw_auth <= 1'b1;
                    if (run_done) begin
                        rsp_status_q  <= run_status;
                        rsp_balance_q <= run_balance;
                        // Idle drives on the same edge so the ATM cannot log in again.
                        drv           <= IDLE_DRV;
                        state         <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (atm_state == ST_WAITING || wd_expired) begin
                        rsp_vld_q <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (req_if.rsp_ready) begin
                        rsp_vld_q <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atm_request_sequencer.sv
// Bench for atm_request_sequencer: a small ATM core stub drives the sequencer's ATM side, and a
// transaction-level model of the account database predicts every response into a scoreboard.
module tb_atm_request_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    atm_request_sequencer_if bus();

    logic [3:0]  atm_acc_num;
    logic [15:0] atm_pin, atm_new_pin;
    logic [31:0] atm_amount;
    logic        atm_language;
    logic [2:0]  atm_operation;
    logic [2:0]  atm_state;
    logic        atm_success;
    logic [31:0] atm_balance;

    atm_request_sequencer dut (
        .clk(clk), .rst(rst), .req_if(bus),
        .atm_acc_num(atm_acc_num), .atm_pin(atm_pin), .atm_new_pin(atm_new_pin),
        .atm_amount(atm_amount), .atm_language(atm_language), .atm_operation(atm_operation),
        .atm_state(atm_state), .atm_success(atm_success), .atm_balance(atm_balance)
    );

    function automatic logic [15:0] init_pin(input int i);
        return (i == 2) ? 16'd1234 : 16'(1000 + 37 * i);
    endfunction
    function automatic logic [31:0] init_bal(input int i);
        return (i == 2) ? 32'd500 : 32'(100 * i + 50);
    endfunction
    function automatic bit acc_present(input logic [3:0] a);
        return a < 4'd10;
    endfunction

    // ATM core stub: WAITING -> AUTH -> MENU -> op state -> WAITING.
    logic [15:0] db_pin [16];
    logic [31:0] db_bal [16];
    logic [3:0]  cur;
    logic        db_loaded = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            atm_state   <= 3'd0;
            atm_success <= 1'b0;
            atm_balance <= '0;
            cur         <= '0;
            if (!db_loaded) begin
                for (int i = 0; i < 16; i++) begin
                    db_pin[i] <= init_pin(i);
                    db_bal[i] <= init_bal(i);
                end
                db_loaded <= 1'b1;
            end
        end else begin
            case (atm_state)
                3'd0: if (acc_present(atm_acc_num)) begin
                    atm_state <= 3'd1;
                    cur       <= atm_acc_num;
                end
                3'd1: atm_state <= (atm_pin == db_pin[cur]) ? 3'd2 : 3'd0;
                3'd2: begin
                    case (atm_operation)
                        3'd3: begin
                            atm_success <= 1'b1;
                            atm_balance <= db_bal[cur];
                        end
                        3'd4: begin
                            if (atm_amount <= db_bal[cur]) begin
                                db_bal[cur] <= db_bal[cur] - atm_amount;
                                atm_balance <= db_bal[cur] - atm_amount;
                                atm_success <= 1'b1;
                            end else begin
                                atm_balance <= db_bal[cur];
                                atm_success <= 1'b0;
                            end
                        end
                        3'd5: begin
                            db_bal[cur] <= db_bal[cur] + atm_amount;
                            atm_balance <= db_bal[cur] + atm_amount;
                            atm_success <= 1'b1;
                        end
                        3'd6: begin
                            db_pin[cur] <= atm_new_pin;
                            atm_balance <= db_bal[cur];
                            atm_success <= 1'b1;
                        end
                        default: ;
                    endcase
                    if (atm_operation >= 3'd3 && atm_operation <= 3'd6)
                        atm_state <= atm_operation;
                end
                default: atm_state <= 3'd0;
            endcase
        end
    end

    // Transaction-level reference: account database and the outcome of each request.
    logic [15:0] ref_pin [16];
    logic [31:0] ref_bal [16];

    typedef struct {
        logic [2:0]  st;
        logic [31:0] bal;
        int          lat;
        int          acc_cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic model(input logic [3:0] acc, input logic [15:0] pin, input logic [2:0] op,
                         input logic [31:0] amt, input logic [15:0] npin, output exp_t e);
        e.bal = 0;
        e.lat = -1;
        e.acc_cyc = 0;
        if (op < 3'd3 || op > 3'd6) begin
            e.st = 3'd4;
            e.lat = 0;
        end else if (!acc_present(acc)) begin
            e.st = 3'd3;
        end else if (pin != ref_pin[acc]) begin
            e.st = 3'd2;
        end else begin
            e.st = 3'd0;
            e.lat = 5;
            case (op)
                3'd4: if (amt <= ref_bal[acc]) ref_bal[acc] = ref_bal[acc] - amt;
                      else e.st = 3'd1;
                3'd5: ref_bal[acc] = ref_bal[acc] + amt;
                3'd6: ref_pin[acc] = npin;
                default: ;
            endcase
            e.bal = ref_bal[acc];
        end
    endtask

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit hold_rdy = 1'b0;
    bit prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: latency at the rising edge of rsp_valid, contents at each handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rsp_valid && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp status=%0d expected no response", bus.rsp_status);
                end else if (exp_q[0].lat >= 0) begin
                    chk("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(exp_q[0].lat));
                end
            end
            if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_status", 32'(bus.rsp_status), 32'(e.st));
                chk("rsp_balance", bus.rsp_balance, e.bal);
                chk("idle_acc_at_rsp", 32'(atm_acc_num), 32'hF);
                chk("idle_op_at_rsp", 32'(atm_operation), 32'd0);
            end
        end
        prev_vld = bus.rsp_valid;
    end

    task automatic send(input logic [3:0] acc, input logic [15:0] pin, input logic [2:0] op,
                        input logic [31:0] amt, input logic [15:0] npin, input logic lang,
                        input bit expect_rsp);
        exp_t e;
        bit ok;
        @(negedge clk);
        bus.req_acc = acc; bus.req_pin = pin; bus.req_op = op;
        bus.req_amount = amt; bus.req_new_pin = npin; bus.req_lang = lang;
        bus.req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout req_ready=0 expected 1 within 50 cycles");
        end else begin
            model(acc, pin, op, amt, npin, e);
            e.acc_cyc = cyc + 1;
            if (expect_rsp) exp_q.push_back(e);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_acc_idle", 32'(atm_acc_num), 32'hF);
        chk("rst_amount_idle", atm_amount, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0]  acc;
        logic [15:0] pin;
        logic [2:0]  op;
        int          r;
        int          seen;
        for (int i = 0; i < 16; i++) begin
            ref_pin[i] = init_pin(i);
            ref_bal[i] = init_bal(i);
        end
        bus.req_valid = 1'b0; bus.req_acc = '0; bus.req_pin = '0; bus.req_op = '0;
        bus.req_amount = '0; bus.req_new_pin = '0; bus.req_lang = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_status", 32'(bus.rsp_status), 32'd0);
        chk("reset_rsp_balance", bus.rsp_balance, 32'd0);
        chk("reset_acc", 32'(atm_acc_num), 32'hF);
        chk("reset_op", 32'(atm_operation), 32'd0);
        chk("reset_pin", 32'(atm_pin), 32'd0);
        chk("reset_new_pin", 32'(atm_new_pin), 32'd0);
        chk("reset_amount", atm_amount, 32'd0);
        chk("reset_lang", 32'(atm_language), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        send(4'd2, 16'd1234, 3'd3, 32'd0, 16'd0, 1'b0, 1'b1);   wait_drain();
        send(4'd2, 16'd1234, 3'd4, 32'd700, 16'd0, 1'b1, 1'b1); wait_drain();
        send(4'd2, 16'd9999, 3'd3, 32'd0, 16'd0, 1'b0, 1'b1);   wait_drain();
        send(4'd2, 16'd1234, 3'd7, 32'd0, 16'd0, 1'b0, 1'b1);   wait_drain();

`ifdef ATM_SEQ_TIMEOUT_EN
        send(4'hE, 16'd1, 3'd3, 32'd0, 16'd0, 1'b0, 1'b1);
        wait_drain();
`else
        send(4'hE, 16'd1, 3'd3, 32'd0, 16'd0, 1'b0, 1'b0);
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("absent_acc_no_rsp", 32'(seen), 32'd0);
        pulse_reset();
`endif

        hold_rdy = 1'b1;
        send(4'd3, ref_pin[3], 3'd5, 32'd100, 16'd0, 1'b0, 1'b1);
        for (int i = 0; i < 50 && !bus.rsp_valid; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("held_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        pulse_reset();
        hold_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_ready", 32'(bus.req_ready), 32'd1);

        for (int n = 0; n < 40; n++) begin
            acc = 4'($urandom_range(0, 9));
            pin = ($urandom_range(0, 3) == 0) ? (ref_pin[acc] ^ 16'h0101) : ref_pin[acc];
            r = int'($urandom_range(0, 9));
            if (r < 8)       op = 3'(3 + r % 4);
            else if (r == 8) op = 3'd7;
            else             op = 3'($urandom_range(0, 2));
            send(acc, pin, op, 32'($urandom_range(0, 600)), 16'($urandom_range(1, 9999)),
                 1'($urandom_range(0, 1)), 1'b1);
            wait_drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
